// File: rtl/tt_um_latch_driver.sv
// Set/reset pulse sequencer for the NOR SR latch tile: debounced buttons in, non-overlapping S/R pulses out.
// Define LATCH_DRV_READBACK_EN to enable the settle/check readback of Q/Qn and the error counters.
module tt_um_latch_driver #(
  parameter int DEB_CYCLES    = 4,
  parameter int PULSE_CYCLES  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SETTLE = 2'b10,
    CHECK  = 2'b11
  } state_e;

  localparam logic [3:0] DEB_MAX   = 4'(DEB_CYCLES);
  localparam logic [3:0] PULSE_LD  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_cnt_q [2];
  logic [3:0] deb_cnt_d [2];
  logic [1:0] deb, deb_prev_q, req_q;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       s_q, s_d, r_q, r_d;
  logic       err_q, err_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       unused_ok;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (!sync2_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] != DEB_MAX) begin
        deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
      end
      deb[i] = (deb_cnt_q[i] == DEB_MAX);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        // Simultaneous set+reset requests (2'b11) are dropped on purpose.
        if (req_q == 2'b01 || req_q == 2'b10) begin
          dir_d   = req_q[0];
          cnt_d   = PULSE_LD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
`ifdef LATCH_DRV_READBACK_EN
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef LATCH_DRV_READBACK_EN
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        // Expected readback is Q=dir, Qn=!dir; 00 and 11 also count as faults.
        if (sync2_q[3:2] != {~dir_q, dir_q}) begin
          err_d = 1'b1;
          if (err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    s_d = (state_d == DRIVE) &&  dir_d;
    r_d = (state_d == DRIVE) && !dir_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      deb_prev_q   <= '0;
      req_q        <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      sync1_q      <= ui_in[3:0];
      sync2_q      <= sync1_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      deb_prev_q   <= deb;
      req_q        <= deb & ~deb_prev_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      s_q          <= s_d;
      r_q          <= r_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign uo_out  = {err_cnt_q, err_q, (state_q != IDLE), r_q, s_q};
  assign uio_out = {6'b0, state_q};
  assign uio_oe  = 8'h00;

`ifdef LATCH_DRV_READBACK_EN
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4], sync2_q[3:2], SETTLE_LD};
`endif

endmodule

// File: tb/tb_tt_um_latch_driver.sv
// Scoreboard bench for tt_um_latch_driver: button presses queue expected S/R pulses, a monitor pops and checks them.
module tb_tt_um_latch_driver;

  localparam int DEB    = 4;
  localparam int PULSE  = 3;
  localparam int SETTLE = 2;
`ifdef LATCH_DRV_READBACK_EN
  localparam int  BUSY_LEN = PULSE + SETTLE + 1;
  localparam bit  RB_EN    = 1'b1;
`else
  localparam int  BUSY_LEN = PULSE;
  localparam bit  RB_EN    = 1'b0;
`endif

  typedef struct {
    int         start;
    logic [1:0] kind;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [1:0] btn = 2'b00;
  logic       fault = 1'b0;
  logic       all_ones = 1'b0;
  logic       latch_q = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;
  int         exp_err = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] prev_sr = 2'b00;
  int         width = 0;
  int         blen = 0;

  tt_um_latch_driver #(
    .DEB_CYCLES   (DEB),
    .PULSE_CYCLES (PULSE),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (1'b1),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (8'h00),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural NOR latch on the other side of the pads; fault forces Q=0, Qn=1.
  always @(negedge clk) begin
    if (uo_out[0]) latch_q <= 1'b1;
    else if (uo_out[1]) latch_q <= 1'b0;
  end

  assign ui_in = all_ones ? 8'hFF : {4'b0000, (fault ? 2'b10 : {~latch_q, latch_q}), btn};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic press(input logic [1:0] b, input int hold, input bit expect_pulse);
    exp_t e;
    @(negedge clk);
    btn = b;
    if (expect_pulse) begin
      e.start = cyc + 1 + DEB + 3;
      e.kind  = b;
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    btn = 2'b00;
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_sticky"}, uo_out[3], exp_err);
    chk({tag, "_err_cnt"}, uo_out[7:4], exp_cnt);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sr = 2'b00;
      width   = 0;
      blen    = 0;
    end else begin
      if (uo_out[0] && uo_out[1]) chk("sr_overlap", 1, 0);
      if (prev_sr == 2'b00 && uo_out[1:0] != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", uo_out[1:0], 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", uo_out[1:0], mon_e.kind);
          chk("pulse_start", cyc, mon_e.start);
          chk("state_drive", uio_out, 1);
        end
        width = 1;
      end else if (uo_out[1:0] != 2'b00) begin
        width++;
      end
      if (prev_sr != 2'b00 && uo_out[1:0] == 2'b00) chk("pulse_width", width, PULSE);
      if (uo_out[2]) begin
        blen++;
      end else if (blen != 0) begin
        chk("busy_len", blen, BUSY_LEN);
        blen = 0;
      end
      prev_sr = uo_out[1:0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n    = 1'b1;
    all_ones = 1'b1;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    all_ones = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_uo_out", uo_out, 8'h00);

    // Set path with a well-behaved latch.
    press(2'b01, 10, 1'b1);
    repeat (15) @(negedge clk);
    chk("set_queue_empty", exp_q.size(), 0);
    chk("set_latch_q", latch_q, 1);
    check_errs("set");

    // Reset path.
    press(2'b10, 10, 1'b1);
    repeat (15) @(negedge clk);
    chk("rst_queue_empty", exp_q.size(), 0);
    chk("rst_latch_q", latch_q, 0);
    check_errs("rst");

    // Glitch shorter than the debounce window.
    seen = 1'b0;
    press(2'b10, DEB - 1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen |= uo_out[2];
    end
    chk("glitch_busy", seen, 0);
    chk("glitch_uo_out", uo_out[1:0], 0);

    // Both buttons rising together.
    press(2'b11, 10, 1'b0);
    repeat (15) @(negedge clk);
    chk("simul_uo_out", uo_out[2:0], 0);
    check_errs("simul");

    // Faulty readback: first fault, then 16 more to saturate the counter.
    fault = 1'b1;
    for (int k = 0; k < 17; k++) begin
      press(2'b01, 10, 1'b1);
      if (RB_EN) begin
        exp_err = 1;
        if (exp_cnt < 15) exp_cnt++;
      end
      repeat (12) @(negedge clk);
      if (k == 0) check_errs("fault_first");
    end
    chk("fault_queue_empty", exp_q.size(), 0);
    check_errs("fault_sat");
    fault = 1'b0;

    // Reset asserted during the second S cycle.
    @(negedge clk);
    btn = 2'b01;
    mon_e.start = cyc + 1 + DEB + 3;
    mon_e.kind  = 2'b01;
    exp_q.push_back(mon_e);
    for (int t = 0; t < 30 && !uo_out[0]; t++) @(negedge clk);
    chk("midrst_s_seen", uo_out[0], 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    btn = 2'b00;
    #1;
    chk("midrst_s_drop", uo_out[0], 0);
    chk("midrst_r_low", uo_out[1], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_err = 0;
    repeat (20) @(negedge clk);
    chk("midrst_state", uio_out, 0);
    chk("midrst_busy", uo_out[2], 0);
    chk("midrst_queue_empty", exp_q.size(), 0);
    check_errs("midrst");

    // Fresh request after the aborted pulse still works.
    press(2'b10, 10, 1'b1);
    repeat (15) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    check_errs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_latch_driver.md
# tt_um_latch_driver

Sequencing driver for the team's cross-coupled NOR SR latch tile: turns two noisy push-button inputs into clean, non-overlapping set/reset pulses and verifies latch state by reading back Q/Qn. It is the initiator side of the latch's S/R interface and sits in its own TinyTapeout slot, wired to the latch tile through pads. It never drives S and R high together.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive high samples required to accept a button (1..15).
- PULSE_CYCLES, 3: width of each S or R pulse in clk cycles (1..15).
- SETTLE_CYCLES, 2: idle cycles between pulse end and readback sample (≥2, covers synchronizer).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  always 1; ignored
- ui_in  in  8  [0] set button, [1] reset button, [2] Q readback, [3] Qn readback, [7:4] unused
- uo_out  out  8  [0] S, [1] R, [2] busy, [3] error_sticky, [7:4] err_cnt
- uio_in  in  8  unused
- uio_out  out  8  {6'b0, state[1:0]}
- uio_oe  out  8  constant 8'h00

## Operation
- All ui_in bits pass through 2-flop synchronizers before use.
- Debounce per button: 4-bit counter increments while synced input is 1, clears on 0, saturates at DEB_CYCLES; deb = (count == DEB_CYCLES).
- Request = rising edge of deb. A set and a reset request in the same cycle: both discarded, no pulse, no error.
- Requests arriving while busy are discarded (not queued).
- FSM states: IDLE(00), DRIVE(01), SETTLE(10), CHECK(11).
  - IDLE: on a single request latch dir (1=set, 0=reset) → DRIVE, load pulse counter.
  - DRIVE: S=dir, R=!dir for exactly PULSE_CYCLES cycles → SETTLE.
  - SETTLE: S=R=0 for SETTLE_CYCLES cycles → CHECK.
  - CHECK: one cycle; compare synced {Q,Qn} with expected {dir,!dir}; mismatch (including 00 or 11) → err_cnt+1 saturating at 15, error_sticky=1 → IDLE.
- busy = (state != IDLE).
- S and R are registered outputs; S&R is never 1.
- error_sticky and err_cnt clear only on reset.

## Timing
- Reset (async assert, sync release): S=0, R=0, busy=0, error_sticky=0, err_cnt=0, state=IDLE, debounce counters 0, synchronizers 0.
- Button-to-pulse latency: ui_in[0] first sampled high at edge N → S high from edge N+DEB_CYCLES+3 (7 cycles with defaults), provided the input stays high.
- Pulse: S (or R) high for exactly PULSE_CYCLES edges, then low.
- Readback sampled at the CHECK cycle, PULSE_CYCLES+SETTLE_CYCLES cycles after pulse start; err_cnt/error_sticky update on the edge leaving CHECK.
- Minimum request-to-request spacing: PULSE_CYCLES+SETTLE_CYCLES+1 cycles of busy.
- Reset asserted mid-pulse: S/R drop to 0 immediately (asynchronous), no readback performed.
- A glitch shorter than DEB_CYCLES samples produces no pulse.

## Configuration
- LATCH_DRV_READBACK_EN defined: SETTLE and CHECK states active as above; ui_in[3:2] used.
- Undefined: DRIVE → IDLE directly; ui_in[3:2] unused; error_sticky and err_cnt tied to 0; busy lasts PULSE_CYCLES cycles.

## Test plan
- Reset: hold rst_n=0 with ui_in=8'hFF → uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00.
- Set path, defaults, latch model correct: ui_in[0]=1 held 10 cycles → S high for exactly 3 cycles starting 7 cycles after first sample, R stays 0, err_cnt=0.
- Glitch: ui_in[1] high 3 cycles then low → R never asserts, busy stays 0.
- Simultaneous: ui_in[1:0]=2'b11 rising together → no S/R pulse, err_cnt unchanged.
- Readback fault: set request with Q/Qn forced 0/1 → after CHECK error_sticky=1, err_cnt=1; 16 further faulty requests → err_cnt saturates at 15.
- Mid-pulse reset: assert rst_n=0 on 2nd S cycle → S=0 in same cycle; after release, state IDLE, no pulse until new debounced edge.
